spi_reg_master: RTL and testbench

- Serial register-bus initiator that drives CSB/SCLK/SDI and samples SDO of the on-board serial register interface: the write/read path to mode, phase_offset, bit_rate and source/pattern registers, and read-back of REV/PLL_lock/FB_R.
- Accepts single-cycle command requests from a local controller (self-test/loader sequencer).
- Runs one framed transaction of 1-4 data bytes per command.
- Returns read data and a done pulse.

---
 rtl/spi_reg_pkg.sv | 33 +++
 rtl/spi_reg_master_tick.sv | 29 ++
 rtl/spi_reg_master.sv | 161 ++++++++++++++++
 tb/tb_spi_reg_master.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the serial register-bus initiator.
// Header layout and the read-only register map of the target live here.
package spi_reg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_HOLD,
    ST_GAP
  } state_e;

  localparam int MIN_CLK_DIV = 4;

  localparam int HDR_RD_BIT   = 7;
  localparam int HDR_ADDR_MSB = 6;

  localparam logic [6:0] ADDR_STATUS = 7'd16;
  localparam logic [6:0] ADDR_FB_R0  = 7'd17;
  localparam logic [6:0] ADDR_FB_R1  = 7'd18;
  localparam logic [6:0] ADDR_FB_R2  = 7'd19;
  localparam logic [6:0] ADDR_FB_R3  = 7'd20;

  function automatic logic [7:0] make_header(input logic rd, input logic [6:0] a);
    logic [7:0] h;
    h = '0;
    h[HDR_RD_BIT] = rd;
    h[HDR_ADDR_MSB:0] = a;
    return h;
  endfunction

endpackage

// File: rtl/spi_reg_master_tick.sv
// Phase timer: down-counter that strobes phase_end_o on its terminal count
// and reloads, so every FSM phase lasts exactly CLK_DIV cycles from entry.
module spi_reg_master_tick #(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic phase_end_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TC_LOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q - 1'b1;
    if (restart_i || cnt_q == '0) cnt_d = TC_LOAD;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign phase_end_o = (cnt_q == '0);

endmodule

// File: rtl/spi_reg_master.sv
// Serial register-bus initiator: frames {rd_nwr, addr} plus 1-4 data bytes
// MSB first on CSB/SCLK/SDI and collects read bytes from a synchronized SDO.
module spi_reg_master
  import spi_reg_pkg::*;
#(
  parameter int CLK_DIV   = 8,
  parameter int MAX_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   rd_nwr,
  input  logic [6:0]             addr,
  input  logic [1:0]             len,
  input  logic [8*MAX_BYTES-1:0] wr_data,
  output logic                   busy,
  output logic                   done,
  output logic [8*MAX_BYTES-1:0] rd_data,
  output logic                   CSB,
  output logic                   SCLK,
  output logic                   SDI,
  input  logic                   SDO
);

  localparam int DW = 8 * MAX_BYTES;
  localparam int FW = DW + 8;
  localparam int BW = $clog2(FW);

  if (CLK_DIV < MIN_CLK_DIV) begin : g_div_check
    $error("spi_reg_master: CLK_DIV=%0d below minimum %0d", CLK_DIV, MIN_CLK_DIV);
  end
  if (MAX_BYTES != 4) begin : g_bytes_check
    $error("spi_reg_master: MAX_BYTES must be 4 (len is 2 bits)");
  end

  state_e        state_q, state_d;
  logic [FW-1:0] tx_q, tx_d;
  logic [DW-1:0] rx_q, rx_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic [1:0]    len_q, len_d;
  logic          rd_q, rd_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic          done_q, done_d;
  logic          csb_q, csb_d;
  logic          sclk_q, sclk_d;
  logic          sdi_q, sdi_d;
  logic          sdo_s1_q, sdo_s_q;

  logic          phase_end;
  logic [BW-1:0] last_bit;
  logic [DW-1:0] wr_stream;
  logic [DW-1:0] rd_unpacked;

  spi_reg_master_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk        (clk),
    .rst        (rst),
    .restart_i  (state_d != state_q),
    .phase_end_o(phase_end)
  );

  assign last_bit = BW'(8 * int'(len_q) + 15);

  // Byte 0 goes out first; read bytes arrive byte 0 first and end up in the high end of rx.
  always_comb begin
    wr_stream   = '0;
    rd_unpacked = '0;
    for (int k = 0; k < MAX_BYTES; k++) begin
      wr_stream[DW-1-8*k -: 8] = wr_data[8*k +: 8];
      if (k <= int'(len_q)) rd_unpacked[8*k +: 8] = rx_q[8*(int'(len_q) - k) +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    len_d     = len_q;
    rd_d      = rd_q;
    bit_cnt_d = bit_cnt_q;
    rd_data_d = rd_data_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SETUP;
          rd_d      = rd_nwr;
          len_d     = len;
          bit_cnt_d = '0;
          rx_d      = '0;
          tx_d      = {make_header(rd_nwr, addr), rd_nwr ? {DW{1'b0}} : wr_stream};
        end
      end
      ST_SETUP:    if (phase_end) state_d = ST_SHIFT_LO;
      ST_SHIFT_LO: if (phase_end) state_d = ST_SHIFT_HI;
      ST_SHIFT_HI: begin
        if (phase_end) begin
          tx_d      = {tx_q[FW-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (rd_q && bit_cnt_q >= BW'(8)) rx_d = {rx_q[DW-2:0], sdo_s_q};
          state_d   = (bit_cnt_q == last_bit) ? ST_HOLD : ST_SHIFT_LO;
        end
      end
      ST_HOLD: if (phase_end) state_d = ST_GAP;
      ST_GAP: begin
        if (phase_end) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          if (rd_q) rd_data_d = rd_unpacked;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pins are decoded from the next state so they leave flops and never glitch.
    csb_d  = (state_d == ST_IDLE) || (state_d == ST_GAP);
    sclk_d = (state_d == ST_SHIFT_HI);
    if (state_d == ST_SHIFT_LO)      sdi_d = tx_d[FW-1];
    else if (state_d == ST_SHIFT_HI) sdi_d = sdi_q;
    else                             sdi_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      tx_q      <= '0;
      rx_q      <= '0;
      rd_data_q <= '0;
      len_q     <= '0;
      rd_q      <= 1'b0;
      bit_cnt_q <= '0;
      done_q    <= 1'b0;
      csb_q     <= 1'b1;
      sclk_q    <= 1'b0;
      sdi_q     <= 1'b0;
      sdo_s1_q  <= 1'b1;
      sdo_s_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rd_data_q <= rd_data_d;
      len_q     <= len_d;
      rd_q      <= rd_d;
      bit_cnt_q <= bit_cnt_d;
      done_q    <= done_d;
      csb_q     <= csb_d;
      sclk_q    <= sclk_d;
      sdi_q     <= sdi_d;
      sdo_s1_q  <= SDO;
      sdo_s_q   <= sdo_s1_q;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign rd_data = rd_data_q;
  assign CSB     = csb_q;
  assign SCLK    = sclk_q;
  assign SDI     = sdi_q;

endmodule

// File: tb/tb_spi_reg_master.sv
// Bench for spi_reg_master: behavioural serial target with a 128-byte register
// map, randomized commands, latency and frame checks against the protocol rules.
module tb_spi_reg_master;

  localparam int CLK_DIV = 8;
  localparam int SDO_DLY = 4;

  logic        clk, rst, start, rd_nwr;
  logic [6:0]  addr;
  logic [1:0]  len;
  logic [31:0] wr_data;
  logic        busy, done;
  logic [31:0] rd_data;
  logic        CSB, SCLK, SDI, SDO;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] exp_rd;

  spi_reg_master #(.CLK_DIV(CLK_DIV), .MAX_BYTES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .rd_nwr(rd_nwr), .addr(addr), .len(len),
    .wr_data(wr_data), .busy(busy), .done(done), .rd_data(rd_data),
    .CSB(CSB), .SCLK(SCLK), .SDI(SDI), .SDO(SDO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- target model ----------------
  logic [7:0] regs [128];
  logic [7:0] sdi_bytes [$];
  int         rises = 0;
  int         bitn = 0;
  logic [7:0] sh_m = 8'h00;
  logic [7:0] hdr_m = 8'h00;
  logic       sdo_drv = 1'b1;
  bit         glitch_en = 1'b0;
  int         hi_cnt = 0;
  int         csb_run = 0;
  int         last_gap = 0;
  int         d_m, idx_m;
  logic [7:0] byte_m;
  logic       b_m;

  always @(negedge CSB) begin
    bitn = 0;
    rises = 0;
    hdr_m = 8'h00;
    sdi_bytes.delete();
  end

  always @(posedge SCLK) begin
    if (CSB === 1'b0) begin
      rises++;
      sh_m = {sh_m[6:0], SDI};
      bitn++;
      if (bitn % 8 == 0) begin
        sdi_bytes.push_back(sh_m);
        if (bitn == 8) hdr_m = sh_m;
        else if (hdr_m[7] == 1'b0) regs[(int'(hdr_m[6:0]) + bitn / 8 - 2) % 128] = sh_m;
      end
    end
  end

  // Next read bit is presented SDO_DLY clocks after each SCLK fall.
  always @(negedge SCLK) begin
    if (CSB === 1'b0 && hdr_m[7] && bitn >= 8) begin
      d_m = bitn - 8;
      idx_m = (int'(hdr_m[6:0]) + d_m / 8) % 128;
      byte_m = regs[idx_m];
      b_m = byte_m[7 - d_m % 8];
      repeat (SDO_DLY) @(posedge clk);
      sdo_drv <= b_m;
    end
  end

  always @(posedge clk) hi_cnt <= SCLK ? hi_cnt + 1 : 0;

  // In glitch mode SDO is only valid late in the high phase.
  assign SDO = CSB ? 1'b1 : ((glitch_en && !(SCLK && hi_cnt >= 3)) ? ~sdo_drv : sdo_drv);

  always @(posedge clk) begin
    if (CSB) csb_run <= csb_run + 1;
    else begin
      if (csb_run != 0) last_gap <= csb_run;
      csb_run <= 0;
    end
  end

  function automatic int lat_exp(input int l);
    return 1 + 3 * CLK_DIV + 16 * CLK_DIV * (l + 2);
  endfunction

  task automatic run_txn(input logic rd, input logic [6:0] a, input logic [1:0] l,
                         input logic [31:0] wd, output int lat, output logic [31:0] rdd,
                         output bit tmo, output logic done_next);
    int t0, n;
    @(negedge clk);
    rd_nwr = rd; addr = a; len = l; wr_data = wd; start = 1'b1; t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    tmo = (done !== 1'b1);
    lat = cyc - t0;
    rdd = rd_data;
    @(negedge clk);
    done_next = done;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; rd_nwr = 1'b0; addr = '0; len = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({CSB, SCLK, SDI, busy, done} !== 5'b10000) begin
      errors++; $display("FAIL reset_pins: got %b expected 10000", {CSB, SCLK, SDI, busy, done});
    end
    checks++;
    if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
    rst = 1'b1;
    @(negedge clk);
    exp_rd = 32'h0;
  endtask

  task automatic test_write_single();
    int lat; logic [31:0] rdd; bit tmo; logic dn;
    run_txn(1'b0, 7'd0, 2'd0, 32'h0000_00A5, lat, rdd, tmo, dn);
    checks++;
    if (tmo || lat != lat_exp(0)) begin errors++; $display("FAIL wr1_latency: got %0d expected %0d", lat, lat_exp(0)); end
    checks++;
    if (sdi_bytes.size() != 2 || sdi_bytes[0] !== 8'h00 || sdi_bytes[1] !== 8'hA5) begin
      errors++; $display("FAIL wr1_stream: got %p expected 00 a5", sdi_bytes);
    end
    checks++;
    if (rises != 16) begin errors++; $display("FAIL wr1_rises: got %0d expected 16", rises); end
    checks++;
    if (rdd !== exp_rd) begin errors++; $display("FAIL wr1_rd_data: got %h expected %h", rdd, exp_rd); end
    checks++;
    if (regs[0] !== 8'hA5) begin errors++; $display("FAIL wr1_target: got %h expected a5", regs[0]); end
    checks++;
    if (dn !== 1'b0) begin errors++; $display("FAIL wr1_done_width: got %b expected 0", dn); end
  endtask

  task automatic test_read_status();
    int lat; logic [31:0] rdd; bit tmo; logic dn;
    run_txn(1'b1, 7'd16, 2'd0, 32'hFFFF_FFFF, lat, rdd, tmo, dn);
    checks++;
    if (tmo || lat != lat_exp(0)) begin errors++; $display("FAIL rd1_latency: got %0d expected %0d", lat, lat_exp(0)); end
    checks++;
    if (sdi_bytes.size() != 2 || sdi_bytes[0] !== 8'h90 || sdi_bytes[1] !== 8'h00) begin
      errors++; $display("FAIL rd1_stream: got %p expected 90 00", sdi_bytes);
    end
    checks++;
    if (rdd !== 32'h0000_005C) begin errors++; $display("FAIL rd1_data: got %h expected 0000005c", rdd); end
    exp_rd = 32'h0000_005C;
  endtask

  task automatic test_write_burst();
    int lat; logic [31:0] rdd; bit tmo; logic dn;
    run_txn(1'b0, 7'd2, 2'd3, 32'h1122_3344, lat, rdd, tmo, dn);
    checks++;
    if (tmo || lat != lat_exp(3)) begin errors++; $display("FAIL wr4_latency: got %0d expected %0d", lat, lat_exp(3)); end
    checks++;
    if (sdi_bytes.size() != 5 || sdi_bytes[0] !== 8'h02 || sdi_bytes[1] !== 8'h44 ||
        sdi_bytes[2] !== 8'h33 || sdi_bytes[3] !== 8'h22 || sdi_bytes[4] !== 8'h11) begin
      errors++; $display("FAIL wr4_stream: got %p expected 02 44 33 22 11", sdi_bytes);
    end
    checks++;
    if (rises != 40) begin errors++; $display("FAIL wr4_rises: got %0d expected 40", rises); end
    checks++;
    if ({regs[5], regs[4], regs[3], regs[2]} !== 32'h1122_3344) begin
      errors++; $display("FAIL wr4_bit_rate: got %h expected 11223344", {regs[5], regs[4], regs[3], regs[2]});
    end
    checks++;
    if (rdd !== exp_rd) begin errors++; $display("FAIL wr4_rd_data: got %h expected %h", rdd, exp_rd); end
  endtask

  task automatic test_busy_ignore();
    int t0, n, lat;
    @(negedge clk);
    rd_nwr = 1'b0; addr = 7'h05; len = 2'd1; wr_data = 32'h0000_C3B2; start = 1'b1; t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + 50) @(negedge clk);
    rd_nwr = 1'b1; addr = 7'h33; len = 2'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    lat = cyc - t0;
    checks++;
    if (done !== 1'b1 || lat != lat_exp(1)) begin errors++; $display("FAIL ign_latency: got %0d expected %0d", lat, lat_exp(1)); end
    checks++;
    if (rises != 24) begin errors++; $display("FAIL ign_rises: got %0d expected 24", rises); end
    checks++;
    if (sdi_bytes.size() != 3 || sdi_bytes[0] !== 8'h05 || sdi_bytes[1] !== 8'hB2 || sdi_bytes[2] !== 8'hC3) begin
      errors++; $display("FAIL ign_stream: got %p expected 05 b2 c3", sdi_bytes);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sdi_bytes.size() != 3) begin
      errors++; $display("FAIL ign_no_queue: got busy=%b bytes=%0d expected busy=0 bytes=3", busy, sdi_bytes.size());
    end
  endtask

  task automatic test_back_to_back();
    int t0, n, lat;
    @(negedge clk);
    rd_nwr = 1'b0; addr = 7'h0A; len = 2'd0; wr_data = 32'h0000_003C; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_done_cycle: got done=%b busy=%b expected 1 0", done, busy); end
    rd_nwr = 1'b1; addr = 7'h0A; len = 2'd0; start = 1'b1; t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy=%b expected 1", busy); end
    n = 0;
    while (done !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    lat = cyc - t0;
    checks++;
    if (done !== 1'b1 || lat != lat_exp(0)) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", lat, lat_exp(0)); end
    checks++;
    if (rd_data !== 32'h0000_003C) begin errors++; $display("FAIL b2b_rd_data: got %h expected 0000003c", rd_data); end
    checks++;
    if (last_gap < CLK_DIV || last_gap > CLK_DIV + 1) begin
      errors++; $display("FAIL b2b_csb_gap: got %0d expected %0d..%0d", last_gap, CLK_DIV, CLK_DIV + 1);
    end
    exp_rd = 32'h0000_003C;
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int t0, n, lat; bit seen; logic [31:0] rdd; bit tmo; logic dn;
    @(negedge clk);
    rd_nwr = 1'b1; addr = 7'd17; len = 2'd3; start = 1'b1; t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while ((cyc < t0 + 100 || SCLK !== 1'b1) && n < 1000) begin @(negedge clk); n++; end
    checks++;
    if (SCLK !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL abort_setup: got sclk=%b busy=%b expected 1 1", SCLK, busy); end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({CSB, SCLK, busy, done} !== 4'b1000) begin
      errors++; $display("FAIL abort_pins: got %b expected 1000", {CSB, SCLK, busy, done});
    end
    checks++;
    if (rd_data !== 32'h0) begin errors++; $display("FAIL abort_rd_data: got %h expected 0", rd_data); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (700) begin
      @(negedge clk);
      if (done === 1'b1 || CSB === 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL abort_quiet: got activity=1 expected 0"); end
    exp_rd = 32'h0;
    run_txn(1'b1, 7'd16, 2'd0, 32'h0, lat, rdd, tmo, dn);
    checks++;
    if (tmo || rdd !== 32'h0000_005C) begin errors++; $display("FAIL abort_recover: got %h expected 0000005c", rdd); end
    exp_rd = 32'h0000_005C;
  endtask

  task automatic test_fb_read();
    int lat; logic [31:0] rdd; bit tmo; logic dn;
    glitch_en = 1'b1;
    run_txn(1'b1, 7'd17, 2'd3, 32'h0, lat, rdd, tmo, dn);
    checks++;
    if (tmo || lat != lat_exp(3)) begin errors++; $display("FAIL fb_latency: got %0d expected %0d", lat, lat_exp(3)); end
    checks++;
    if (rdd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fb_rd_data: got %h expected deadbeef", rdd); end
    checks++;
    if (sdi_bytes.size() != 5 || sdi_bytes[0] !== 8'h91 ||
        {sdi_bytes[1], sdi_bytes[2], sdi_bytes[3], sdi_bytes[4]} !== 32'h0) begin
      errors++; $display("FAIL fb_stream: got %p expected 91 00 00 00 00", sdi_bytes);
    end
    exp_rd = 32'hDEAD_BEEF;
  endtask

  task automatic test_random();
    int lat; logic [31:0] rdd; bit tmo; logic dn;
    logic rd; logic [6:0] a; logic [1:0] l; logic [31:0] wd, exp;
    bit ok;
    for (int i = 0; i < 8; i++) begin
      rd = 1'($urandom_range(0, 1));
      a  = 7'($urandom_range(0, 127));
      l  = 2'($urandom_range(0, 3));
      wd = $urandom;
      exp = 32'h0;
      for (int k = 0; k < 4; k++)
        if (k <= int'(l)) exp[8*k +: 8] = regs[(int'(a) + k) % 128];
      run_txn(rd, a, l, wd, lat, rdd, tmo, dn);
      checks++;
      if (tmo || lat != lat_exp(int'(l))) begin
        errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, lat_exp(int'(l)));
      end
      checks++;
      if (sdi_bytes.size() != int'(l) + 2 || sdi_bytes[0] !== {rd, a}) begin
        errors++; $display("FAIL rnd%0d_header: got %p expected %h plus %0d bytes", i, sdi_bytes, {rd, a}, int'(l) + 1);
      end
      if (rd) begin
        checks++;
        if (rdd !== exp) begin errors++; $display("FAIL rnd%0d_read: got %h expected %h", i, rdd, exp); end
        exp_rd = exp;
      end else begin
        checks++;
        if (rdd !== exp_rd) begin errors++; $display("FAIL rnd%0d_rd_kept: got %h expected %h", i, rdd, exp_rd); end
        ok = 1'b1;
        for (int k = 0; k < 4; k++)
          if (k <= int'(l) && regs[(int'(a) + k) % 128] !== wd[8*k +: 8]) ok = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL rnd%0d_write: target bytes differ from %h at addr %h len %0d", i, wd, a, l); end
      end
    end
  endtask

  initial begin
    #500_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 128; i++) regs[i] = 8'($urandom);
    regs[16] = 8'h5C;
    regs[17] = 8'hEF;
    regs[18] = 8'hBE;
    regs[19] = 8'hAD;
    regs[20] = 8'hDE;
    test_reset();
    test_write_single();
    test_read_status();
    test_write_burst();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    test_fb_read();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
